// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;
    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fq_state_e;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order {instruction, PC} buffer with push/pop/flush and occupancy count
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [INSTR_W-1:0]        push_instr,
    input  logic [ADDR_W-1:0]         push_pc,
    input  logic                      pop,
    input  logic                      flush,
    output logic [INSTR_W-1:0]        head_instr,
    output logic [ADDR_W-1:0]         head_pc,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_d [DEPTH];

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // When full, a same-cycle pop frees the slot the push overwrites.
            if (push) begin
                instr_mem_d[wr_ptr_q] = push_instr;
                pc_mem_d[wr_ptr_q]    = push_pc;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

    assign head_instr = instr_mem_q[rd_ptr_q];
    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential fetch issue, credit and redirect control; FETCH_QUEUE_PERF_EN adds perf counters
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                CLK,
    input  logic                Reset_L,
    input  logic [ADDR_W-1:0]   startPC,
    output logic                imemReqValid,
    output logic [ADDR_W-1:0]   imemReqAddr,
    input  logic                imemReqReady,
    input  logic                imemRespValid,
    input  logic [INSTR_W-1:0]  imemRespData,
    output logic                instrValid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instrPC,
    input  logic                instrTake,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirectPC
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]         perfStall,
    output logic [15:0]         perfDrop,
    output logic [15:0]         perfRedirect
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fq_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]   stale_cnt_q, stale_cnt_d;
    logic               req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               accept, drop_stale, push, pop;

    assign accept     = req_valid_q && imemReqReady;
    assign drop_stale = imemRespValid && (stale_cnt_q != '0);
    assign push       = imemRespValid && !drop_stale && !redirect;
    assign pop        = instrTake && (count_q != '0) && !redirect;

    always_comb begin
        out_cnt_d   = out_cnt_q + CNT_W'(accept) - CNT_W'(imemRespValid);
        stale_cnt_d = stale_cnt_q - CNT_W'(drop_stale);
        fetch_pc_d  = accept ? fetch_pc_q + PC_INC : fetch_pc_q;
        resp_pc_d   = push ? resp_pc_q + PC_INC : resp_pc_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        state_d     = state_q;
        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old stream.
            fetch_pc_d  = align_pc(redirectPC);
            resp_pc_d   = align_pc(redirectPC);
            stale_cnt_d = out_cnt_d;
            count_d     = '0;
            state_d     = (out_cnt_d != '0) ? ST_FLUSH : ST_RUN;
        end else if (state_q == ST_FLUSH && stale_cnt_d == '0) begin
            state_d = ST_RUN;
        end
        // Reserving FIFO space for every in-flight request lets responses always be accepted.
        req_valid_d = (state_d == ST_RUN) && (int'(out_cnt_d) < MAX_OUT) &&
                      (int'(count_d) + int'(out_cnt_d) < DEPTH);
        req_addr_d  = fetch_pc_d;
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q     <= ST_RUN;
            fetch_pc_q  <= align_pc(startPC);
            resp_pc_q   <= align_pc(startPC);
            out_cnt_q   <= '0;
            stale_cnt_q <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            out_cnt_q   <= out_cnt_d;
            stale_cnt_q <= stale_cnt_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (Reset_L),
        .push       (push),
        .push_instr (imemRespData),
        .push_pc    (resp_pc_q),
        .pop        (pop),
        .flush      (redirect),
        .head_instr (instr),
        .head_pc    (instrPC),
        .count      (count_q)
    );

    assign imemReqValid = req_valid_q;
    assign imemReqAddr  = req_addr_q;
    assign instrValid   = (count_q != '0);

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_drop_q, perf_drop_d;
    logic [15:0] perf_redirect_q, perf_redirect_d;
    logic        stall_hit;

    assign stall_hit = (count_q == '0) && (state_q == ST_RUN);

    always_comb begin
        perf_stall_d    = perf_stall_q;
        perf_drop_d     = perf_drop_q;
        perf_redirect_d = perf_redirect_q;
        if (stall_hit && perf_stall_q != '1)     perf_stall_d    = perf_stall_q + 32'd1;
        if (drop_stale && perf_drop_q != '1)     perf_drop_d     = perf_drop_q + 16'd1;
        if (redirect && perf_redirect_q != '1)   perf_redirect_d = perf_redirect_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            perf_stall_q    <= '0;
            perf_drop_q     <= '0;
            perf_redirect_q <= '0;
        end else begin
            perf_stall_q    <= perf_stall_d;
            perf_drop_q     <= perf_drop_d;
            perf_redirect_q <= perf_redirect_d;
        end
    end

    assign perfStall    = perf_stall_q;
    assign perfDrop     = perf_drop_q;
    assign perfRedirect = perf_redirect_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue with an in-order memory model
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [63:0] startPC;
    logic        imemReqValid;
    logic [63:0] imemReqAddr;
    logic        imemReqReady;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        instrValid;
    logic [31:0] instr;
    logic [63:0] instrPC;
    logic        instrTake;
    logic        redirect;
    logic [63:0] redirectPC;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perfStall;
    logic [15:0] perfDrop;
    logic [15:0] perfRedirect;
`endif

    always #5 CLK = ~CLK;

    fetch_queue #(
        .DEPTH   (4),
        .MAX_OUT (2)
    ) dut (
        .CLK           (CLK),
        .Reset_L       (Reset_L),
        .startPC       (startPC),
        .imemReqValid  (imemReqValid),
        .imemReqAddr   (imemReqAddr),
        .imemReqReady  (imemReqReady),
        .imemRespValid (imemRespValid),
        .imemRespData  (imemRespData),
        .instrValid    (instrValid),
        .instr         (instr),
        .instrPC       (instrPC),
        .instrTake     (instrTake),
        .redirect      (redirect),
        .redirectPC    (redirectPC)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perfStall     (perfStall),
        .perfDrop      (perfDrop),
        .perfRedirect  (perfRedirect)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;

    req_t        memq[$];
    int          lat = 1;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          take_cnt = 0;
    bit          chk_seq = 0;
    logic [63:0] exp_pc = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample the handshakes that this edge will see, step, then drive the memory reply.
    task automatic tick();
        logic        hs;
        logic [63:0] a;
        req_t        r;
        hs = imemReqValid && imemReqReady && Reset_L;
        a  = imemReqAddr;
        if (chk_seq && instrValid && instrTake && Reset_L) begin
            check_eq("seq_pc", instrPC, exp_pc);
            check_eq("seq_data", {32'h0, instr}, {32'h0, ~exp_pc[31:0]});
            exp_pc = exp_pc + 64'd4;
            take_cnt++;
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (hs) begin
            r.addr = a;
            r.due  = cyc + lat;
            memq.push_back(r);
            hs_cnt++;
        end
        redirect = 1'b0;
        if (memq.size() > 0 && memq[0].due <= cyc + 1) begin
            imemRespValid = 1'b1;
            imemRespData  = ~memq[0].addr[31:0];
            void'(memq.pop_front());
        end else begin
            imemRespValid = 1'b0;
            imemRespData  = '0;
        end
    endtask

    task automatic do_reset(input logic [63:0] start);
        Reset_L       = 1'b0;
        startPC       = start;
        memq.delete();
        imemRespValid = 1'b0;
        redirect      = 1'b0;
        instrTake     = 1'b0;
        imemReqReady  = 1'b1;
        chk_seq       = 0;
        repeat (2) tick();
        Reset_L  = 1'b1;
        hs_cnt   = 0;
        take_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int flush_cyc;
        int stall;
        bit stable;

        Reset_L       = 1'b0;
        startPC       = 64'h1000;
        imemReqReady  = 1'b1;
        imemRespValid = 1'b0;
        imemRespData  = '0;
        instrTake     = 1'b0;
        redirect      = 1'b0;
        redirectPC    = '0;
        repeat (3) tick();

        check_eq("rst_req_valid", imemReqValid, 0);
        check_eq("rst_req_addr", imemReqAddr, 0);
        check_eq("rst_instr_valid", instrValid, 0);
        check_eq("rst_instr", instr, 0);
        check_eq("rst_instr_pc", instrPC, 0);
`ifdef FETCH_QUEUE_PERF_EN
        check_eq("rst_perf_stall", perfStall, 0);
        check_eq("rst_perf_drop", perfDrop, 0);
        check_eq("rst_perf_redirect", perfRedirect, 0);
`endif

        Reset_L = 1'b1;
        tick();
        check_eq("first_req_valid", imemReqValid, 1);
        check_eq("first_req_addr", imemReqAddr, 64'h1000);
        check_eq("first_instr_valid", instrValid, 0);

        // Streaming, latency 1, core always taking
        instrTake = 1'b1;
        exp_pc    = 64'h1000;
        chk_seq   = 1;
        take_cnt  = 0;
        stall     = 0;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (i >= 3 && !instrValid) stall++;
        end
        check_eq("a_stall_cycles", stall, 0);
        check_eq("a_take_count", take_cnt, 17);

        // Core stalled: the FIFO plus in-flight window caps issue at DEPTH
        do_reset(64'h1000);
        tick();
        repeat (11) tick();
        check_eq("b_issued", hs_cnt, 4);
        check_eq("b_req_valid_full", imemReqValid, 0);
        check_eq("b_instr_valid", instrValid, 1);
        instrTake = 1'b1;
        chk_seq   = 1;
        exp_pc    = 64'h1000;
        tick();
        instrTake = 1'b0;
        chk_seq   = 0;
        check_eq("b_reissue_valid", imemReqValid, 1);
        check_eq("b_reissue_addr", imemReqAddr, 64'h1010);
        repeat (5) tick();
        check_eq("b_issued_after_take", hs_cnt, 5);
        check_eq("b_req_valid_refull", imemReqValid, 0);

        // Redirect with two requests in flight at latency 3
        lat = 3;
        do_reset(64'h1000);
        tick();
        tick();
        redirect   = 1'b1;
        redirectPC = 64'h2000;
        tick();
        flush_cyc = 0;
        for (int i = 0; i < 10 && !imemReqValid; i++) begin
            flush_cyc++;
            check_eq("c_no_old_instr", instrValid, 0);
            tick();
        end
        check_eq("c_flush_cycles", flush_cyc, 3);
        check_eq("c_restart_valid", imemReqValid, 1);
        check_eq("c_restart_addr", imemReqAddr, 64'h2000);
`ifdef FETCH_QUEUE_PERF_EN
        check_eq("c_perf_drop", perfDrop, 2);
        check_eq("c_perf_redirect", perfRedirect, 1);
`endif
        instrTake = 1'b1;
        chk_seq   = 1;
        exp_pc    = 64'h2000;
        take_cnt  = 0;
        repeat (10) tick();
        check_eq("c_take_count", take_cnt, 4);

        // Redirect and take in the same cycle as a live response
        lat = 1;
        do_reset(64'h1000);
        instrTake = 1'b1;
        chk_seq   = 1;
        exp_pc    = 64'h1000;
        repeat (8) tick();
        check_eq("d_pre_instr_valid", instrValid, 1);
        redirect   = 1'b1;
        redirectPC = 64'h4000;
        tick();
        check_eq("d_flush_empty", instrValid, 0);
        exp_pc   = 64'h4000;
        take_cnt = 0;
        repeat (8) tick();
        check_eq("d_take_count", take_cnt, 5);

        // Memory back-pressure holds the request; redirect address is aligned
        lat = 1;
        do_reset(64'h1000);
        imemReqReady = 1'b0;
        tick();
        stable = 1;
        repeat (5) begin
            tick();
            if (!(imemReqValid === 1'b1 && imemReqAddr === 64'h1000)) stable = 0;
        end
        check_eq("e_req_stable", stable, 1);
        check_eq("e_no_accept", hs_cnt, 0);
`ifdef FETCH_QUEUE_PERF_EN
        check_eq("e_perf_stall", perfStall, 6);
`endif
        redirect   = 1'b1;
        redirectPC = 64'h3003;
        tick();
        check_eq("e_redirect_valid", imemReqValid, 1);
        check_eq("e_redirect_addr", imemReqAddr, 64'h3000);
        imemReqReady = 1'b1;
        tick();
        check_eq("e_next_addr", imemReqAddr, 64'h3004);
        check_eq("e_accepts", hs_cnt, 1);

        // Asynchronous reset with requests in flight and instructions buffered
        lat = 3;
        do_reset(64'h1000);
        repeat (7) tick();
        check_eq("f_pre_instr_valid", instrValid, 1);
        #2;
        Reset_L = 1'b0;
        #1;
        check_eq("f_rst_req_valid", imemReqValid, 0);
        check_eq("f_rst_req_addr", imemReqAddr, 0);
        check_eq("f_rst_instr_valid", instrValid, 0);
        check_eq("f_rst_instr", instr, 0);
        check_eq("f_rst_instr_pc", instrPC, 0);
        do_reset(64'h5000);
        tick();
        check_eq("f_restart_valid", imemReqValid, 1);
        check_eq("f_restart_addr", imemReqAddr, 64'h5000);
        instrTake = 1'b1;
        chk_seq   = 1;
        exp_pc    = 64'h5000;
        repeat (8) tick();
        check_eq("f_took_new_stream", take_cnt != 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
